// File: rtl/uart_tx_arb.sv
// uart_tx_arb: packet-level round-robin arbiter sharing one UART transmitter among NUM_REQ requesters.
// A grant is held until the owner's last byte transfers or MAX_PKT_LEN bytes have gone out.
module uart_tx_arb #(
  parameter int NUM_REQ     = 4,
  parameter int MAX_PKT_LEN = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [NUM_REQ-1:0]     req_last_i,
  input  logic [NUM_REQ*8-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  output logic [NUM_REQ-1:0]     grant_o,
  output logic                   busy_o,
  output logic                   trunc_o,
  output logic                   tx_data_valid_o,
  output logic [7:0]             tx_data_o,
  input  logic                   tx_data_ready_i
);
  localparam int GW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_PKT_LEN + 1);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t r_state, w_state_nxt;
  logic [GW-1:0] r_idx, r_ptr, w_win;
  logic [CW-1:0] r_cnt;
  logic r_trunc, w_found, w_busy, w_valid, w_last, w_xfer, w_cap, w_rel;
  logic [NUM_REQ-1:0] w_onehot;
  // Scan downward so the last hit is the nearest requester after r_ptr.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int i = NUM_REQ; i >= 1; i--)
      if (req_valid_i[(int'(r_ptr) + i) % NUM_REQ]) begin
        w_found = 1'b1;
        w_win   = GW'((int'(r_ptr) + i) % NUM_REQ);
      end
  end
  assign w_busy          = r_state == BUSY;
  assign w_onehot        = w_busy ? NUM_REQ'(1) << r_idx : '0;
  assign w_valid         = w_busy & req_valid_i[r_idx];
  assign w_last          = req_last_i[r_idx];
  assign w_xfer          = w_valid & tx_data_ready_i;
  assign w_cap           = r_cnt == CW'(MAX_PKT_LEN - 1);
  assign w_rel           = w_xfer & (w_last | w_cap);
  assign tx_data_valid_o = w_valid;
  assign tx_data_o       = w_valid ? req_data_i[int'(r_idx)*8 +: 8] : '0;
  assign req_ready_o     = tx_data_ready_i ? w_onehot : '0;
  assign grant_o         = w_onehot;
  assign busy_o          = w_busy;
  assign trunc_o         = r_trunc;
  always_comb begin
    w_state_nxt = w_busy ? (w_rel ? IDLE : BUSY) : (en_i && w_found ? BUSY : IDLE);
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_idx   <= '0;
      r_ptr   <= GW'(NUM_REQ - 1);
      r_cnt   <= '0;
      r_trunc <= 1'b0;
    end else begin
      r_trunc <= w_rel & ~w_last;
      if (!w_busy && en_i && w_found) begin
        r_idx <= w_win;
        r_cnt <= '0;
      end else if (w_xfer) r_cnt <= r_cnt + CW'(1);
      if (w_rel) r_ptr <= r_idx;
    end
  end
endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: directed and random checks of uart_tx_arb against a per-cycle packet-level model.
module tb_uart_tx_arb;
  localparam int N = 4, MAXL = 4;
  logic clk = 0, rst, en, txr, busy, trunc, txv;
  logic [N-1:0] vld, lst, rdy_o, gnt;
  logic [N*8-1:0] dat;
  logic [7:0] txd;
  logic [8:0] q [N][$];
  logic [7:0] log_d [$];
  logic [N-1:0] log_g [$];
  int vec = 0, errs = 0, cyc = 0, trunc_seen = 0;
  int m_owner, m_ptr, m_cnt, gap_pct, rdy_mode;
  bit m_trunc, en_rand;
  bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic [7:0] wd_exp [8] = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h60, 8'h61, 8'h54, 8'h55};

  always #5 clk = ~clk;

  uart_tx_arb #(.NUM_REQ(N), .MAX_PKT_LEN(MAXL)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .req_valid_i(vld), .req_last_i(lst),
    .req_data_i(dat), .req_ready_o(rdy_o), .grant_o(gnt), .busy_o(busy),
    .trunc_o(trunc), .tx_data_valid_o(txv), .tx_data_o(txd), .tx_data_ready_i(txr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_pkt(input int k, input logic [7:0] base, input int len);
    for (int i = 0; i < len; i++) q[k].push_back({i == len - 1, 8'(base + i)});
  endtask

  task automatic model_reset();
    m_owner = -1; m_ptr = N - 1; m_cnt = 0; m_trunc = 0;
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      vld[k] = q[k].size() > 0 && $urandom_range(99) >= gap_pct;
      dat[k*8 +: 8] = q[k].size() > 0 ? q[k][0][7:0] : 8'($urandom);
      lst[k] = q[k].size() > 0 ? q[k][0][8] : 1'($urandom);
    end
    txr = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? pat[cyc % 4] : 1'($urandom);
    if (en_rand) en = $urandom_range(9) != 0;
  endtask

  task automatic step();
    logic [N-1:0] eg, er;
    logic ev;
    logic [7:0] ed;
    drive();
    @(negedge clk);
    eg = '0; er = '0; ev = 0; ed = '0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      er[m_owner] = txr;
      ev = vld[m_owner];
      ed = ev ? dat[m_owner*8 +: 8] : 8'h00;
    end
    chk("grant", gnt, eg);
    chk("ready", rdy_o, er);
    chk("tx_valid", txv, ev);
    chk("tx_data", txd, ed);
    chk("busy", busy, m_owner >= 0);
    chk("trunc", trunc, m_trunc);
    if (trunc === 1'b1) trunc_seen++;
    if (txv === 1'b1 && txr) begin
      log_d.push_back(txd);
      log_g.push_back(gnt);
    end
    m_trunc = 0;
    if (m_owner < 0) begin
      if (en && |vld)
        for (int j = 1; j <= N; j++) begin
          int c;
          c = (m_ptr + j) % N;
          if (vld[c]) begin
            m_owner = c;
            m_cnt = 0;
            break;
          end
        end
    end else if (vld[m_owner] && txr) begin
      bit l;
      l = q[m_owner][0][8];
      void'(q[m_owner].pop_front());
      m_cnt++;
      if (l || m_cnt == MAXL) begin
        m_trunc = !l;
        m_ptr = m_owner;
        m_owner = -1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int max);
    int n = 0;
    while ((q[0].size() + q[1].size() + q[2].size() + q[3].size() > 0 || m_owner >= 0) && n < max) begin
      step();
      n++;
    end
    chk("drain_in_budget", n < max, 1);
  endtask

  task automatic do_reset();
    rst = 1; en = 1; vld = '0; lst = '0; dat = '0; txr = 1;
    for (int k = 0; k < N; k++) q[k].delete();
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_grant", gnt, 0);
    chk("rst_ready", rdy_o, 0);
    chk("rst_txv", txv, 0);
    chk("rst_txd", txd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_trunc", trunc, 0);
    rst = 0;
  endtask

  task automatic clear_log();
    log_d.delete(); log_g.delete();
  endtask

  initial begin
    rst = 1; en = 1; vld = '0; lst = '0; dat = '0; txr = 1;
    gap_pct = 0; rdy_mode = 0; en_rand = 0;
    do_reset();
    push_pkt(2, 8'h41, 3);
    clear_log();
    step();
    chk("single_grant", gnt, 4'b0100);
    run(40);
    chk("single_n", log_d.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk("single_byte", log_d[i], 8'h41 + i);
      chk("single_owner", log_g[i], 4'b0100);
    end
    chk("single_release", gnt, 0);
    do_reset();
    for (int p = 0; p < 3; p++)
      for (int k = 0; k < N; k++) push_pkt(k, 8'(k*16 + p*2), 2);
    clear_log();
    run(200);
    chk("rr_n", log_g.size(), 24);
    for (int i = 0; i < 24; i++) chk("rr_order", log_g[i], 32'(1) << ((i / 2) % 4));
    rdy_mode = 1;
    push_pkt(1, 8'h10, 4);
    clear_log();
    run(60);
    rdy_mode = 0;
    chk("bp_n", log_d.size(), 4);
    for (int i = 0; i < 4; i++) chk("bp_byte", log_d[i], 8'h10 + i);
    do_reset();
    push_pkt(0, 8'h50, 6);
    push_pkt(1, 8'h60, 2);
    clear_log();
    trunc_seen = 0;
    run(100);
    chk("wd_n", log_d.size(), 8);
    for (int i = 0; i < 8; i++) chk("wd_byte", log_d[i], wd_exp[i]);
    chk("wd_trunc_pulses", trunc_seen, 1);
    en = 0;
    push_pkt(3, 8'h70, 2);
    repeat (10) step();
    chk("en_hold", gnt, 0);
    en = 1;
    step();
    chk("en_grant", gnt, 4'b1000);
    run(40);
    push_pkt(3, 8'h80, 4);
    step();
    chk("en_mid_grant", gnt, 4'b1000);
    push_pkt(2, 8'h90, 2);
    step();
    en = 0;
    for (int n = 0; n < 20 && m_owner >= 0; n++) step();
    chk("en_mid_done", gnt, 0);
    repeat (5) step();
    chk("en_block", gnt, 0);
    chk("en_pending", q[2].size(), 2);
    en = 1;
    run(40);
    do_reset();
    push_pkt(0, 8'hA0, 1);
    run(20);
    push_pkt(2, 8'hB0, 4);
    step();
    step();
    drive();
    #2 rst = 1;
    #1;
    chk("arst_grant", gnt, 0);
    chk("arst_txv", txv, 0);
    chk("arst_busy", busy, 0);
    model_reset();
    @(posedge clk);
    #1 rst = 0;
    cyc++;
    push_pkt(0, 8'hC0, 2);
    push_pkt(1, 8'hD0, 2);
    clear_log();
    run(100);
    chk("arst_first_owner", log_g[0], 4'b0001);
    do_reset();
    gap_pct = 25; rdy_mode = 2; en_rand = 1;
    for (int r = 0; r < 400; r++) begin
      if ($urandom_range(3) == 0) begin
        int k;
        k = $urandom_range(N - 1);
        if (q[k].size() < 8) push_pkt(k, 8'($urandom), $urandom_range(1, 6));
      end
      step();
    end
    gap_pct = 0; en_rand = 0; en = 1;
    run(2000);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Packet-level round-robin arbiter that shares one UART transmitter between NUM_REQ requesters.
- Sits between client blocks (debug console, telemetry, command responder) and the tx_data_valid/ready/data port of the UART top.
- Each grant is held until the requester's last byte is accepted, so packets are never interleaved on the serial line.
- A byte-count watchdog forcibly releases a requester that exceeds MAX_PKT_LEN bytes.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- MAX_PKT_LEN, 64: maximum bytes per grant before forced release, 1..256.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- en_i  in  1  high permits new grants; low blocks new grants only (a packet in flight completes).
- req_valid_i  in  NUM_REQ  per-requester byte valid.
- req_last_i  in  NUM_REQ  per-requester end-of-packet flag, qualified by req_valid_i.
- req_data_i  in  NUM_REQ*8  per-requester byte; requester k occupies bits [8k+7:8k].
- req_ready_o  out  NUM_REQ  per-requester byte accepted.
- grant_o  out  NUM_REQ  one-hot current owner; all zero when idle.
- busy_o  out  1  high in BUSY.
- trunc_o  out  1  one-cycle pulse when the watchdog forces a release.
- tx_data_valid_o  out  1  to UART tx_data_valid_i.
- tx_data_o  out  8  to UART tx_data_i.
- tx_data_ready_i  in  1  from UART tx_data_ready_o.

Behaviour:
- Handshake: a byte transfers on any cycle where tx_data_valid_o && tx_data_ready_i.
- Reset (async assert, sync release) values:
  - state=IDLE, grant_o=0, rr_ptr=NUM_REQ-1, byte count=0.
  - busy_o=0, trunc_o=0, tx_data_valid_o=0, tx_data_o=0, req_ready_o=0.
- IDLE state:
  - tx_data_valid_o=0, req_ready_o=0, tx_data_o=0.
  - If en_i && |req_valid_i: the winner is the first set requester scanning upward from rr_ptr+1 (mod NUM_REQ).
  - Next cycle: grant_o=onehot(winner), state=BUSY, count=0.
  - Arbitration is one cycle, registered. The first byte cannot transfer in the cycle the request is first seen.
- BUSY state, owner g:
  - Combinational pass-through: tx_data_valid_o=req_valid_i[g], tx_data_o=req_data_i[g], req_ready_o[g]=tx_data_ready_i. All other req_ready_o bits are 0.
  - tx_data_o is 0 whenever tx_data_valid_o=0.
  - On each transfer, count increments (width clog2(MAX_PKT_LEN+1)).
- Release from BUSY:
  - Normal: transfer with req_last_i[g]=1 → IDLE, rr_ptr=g, grant_o=0 next cycle.
  - Watchdog: transfer where count==MAX_PKT_LEN-1 and req_last_i[g]=0 → IDLE, rr_ptr=g, trunc_o=1 for exactly the next cycle.
  - The requester is not notified beyond its ready dropping. Its remaining bytes are treated as a new packet that must re-arbitrate.
  - If the last byte coincides with count==MAX_PKT_LEN-1, the release is normal and trunc_o stays 0.
- Owner drops req_valid_i mid-packet: the grant is held and tx_data_valid_o=0. There is no timeout other than byte count.
- en_i deasserted in BUSY: no effect until release. After release, stay IDLE while en_i=0.
- Single requester: re-granted after one IDLE cycle. There is always at least one idle cycle between packets.
- Requests arriving during BUSY are ignored until IDLE. A request asserted in the same cycle as a release is seen by the next IDLE evaluation.
- Grant index and rr_ptr widths are clog2(NUM_REQ). Pointer wrap is modulo NUM_REQ, including non-power-of-two NUM_REQ.
- Fixed invariants: grant_o is always one-hot or zero, and at most one req_ready_o bit is high.

Test Plan:
- Single packet: reset, then req 2 sends 3 bytes 0x41,0x42,0x43 (last on 0x43), tx_data_ready_i always 1.
  - grant_o=0100 one cycle after req_valid_i[2].
  - tx_data_o=0x41,0x42,0x43 on consecutive cycles.
  - grant_o=0 the cycle after 0x43.
- Round-robin: all 4 requesters hold continuous 2-byte packets from reset.
  - Grant order 0,1,2,3,0,1.
  - Each grant carries exactly 2 transfers.
  - No byte from a non-owner appears on tx_data_o.
- Backpressure: tx_data_ready_i toggles 1,0,0,1, with req 1 holding a 4-byte packet 0x10..0x13.
  - tx_data_o holds a byte stable while not ready.
  - req_ready_o[1] mirrors tx_data_ready_i.
  - All 4 bytes are delivered in order.
- Watchdog, MAX_PKT_LEN=4: req 0 streams 6 bytes with last only on byte 6.
  - Release after byte 4.
  - trunc_o pulses for 1 cycle.
  - With req 1 pending, req 1 is granted next; req 0 bytes 5–6 follow later.
- Enable gating: en_i=0 with req 3 valid → grant_o stays 0 indefinitely. en_i=1 → grant_o=1000 on the next cycle.
  - Deassert en_i mid-packet → the packet completes, then no new grant.
- Reset mid-packet: assert rst_i during byte 2 of a packet.
  - In the same cycle (asynchronous): grant_o=0, tx_data_valid_o=0, busy_o=0.
  - After release, the first grant goes to req 0 (rr_ptr reset to NUM_REQ-1).
